// File: rtl/neuro_pkg.sv
// Shared definitions for the neuromorphic datapath: widths, the synapse
// update FSM encoding, and the saturating add used by synapse and neuron.
package neuro_pkg;

  localparam int ISYN_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECAY  = 2'd1,
    SCAN   = 2'd2,
    OUTPUT = 2'd3
  } syn_state_e;

  // Add in one extra bit so the carry is visible, then clamp to the ceiling.
  function automatic logic [ISYN_WIDTH-1:0] sat_add(
    input logic [ISYN_WIDTH-1:0]   a,
    input logic [WEIGHT_WIDTH-1:0] b,
    input logic [ISYN_WIDTH-1:0]   max_val
  );
    logic [ISYN_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[ISYN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// Per-input weight storage: one synchronous write port, one combinational
// read port. A write and a read of the same entry in one cycle returns the
// old value; the new value is visible from the next cycle.
module synapse_weight_rf
  import neuro_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int AW   = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [WEIGHT_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]           raddr_i,
  output logic [WEIGHT_WIDTH-1:0] rdata_o
);

  logic [WEIGHT_WIDTH-1:0] mem_q [N_IN];
  logic                    addr_ok;

  // Writes to indices beyond the populated entries are silently dropped.
  assign addr_ok = (32'(waddr_i) < N_IN);

  // Weight storage; cleared to zero on reset.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && addr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synapse_current_gen.sv
// Synaptic current generator: collects sticky presynaptic spikes and, on an
// accepted tick, decays the accumulator then walks the inputs one per cycle
// adding weights of the spiking ones, finally publishing the result on isyn.
//
// Handshake: tick is a single-cycle request, accepted only while busy is low
// (FSM idle); requests while busy are dropped, not queued. isyn_valid is a
// one-cycle pulse marking that isyn has just been updated; there is no
// downstream backpressure.
module synapse_current_gen
  import neuro_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int TAU      = 2,
  parameter int ISYN_MAX = 255,
  parameter int AW       = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN-1:0]         spike_in,
  input  logic                    tick,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [ISYN_WIDTH-1:0]   isyn,
  output logic                    isyn_valid,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  localparam logic [ISYN_WIDTH-1:0] ISYN_MAX_C = ISYN_WIDTH'(ISYN_MAX);
  localparam logic [AW-1:0]         LAST_IDX   = AW'(N_IN - 1);

  syn_state_e              state_q, state_d;
  logic [ISYN_WIDTH-1:0]   acc_q, acc_d;
  logic [ISYN_WIDTH-1:0]   isyn_q, isyn_d;
  logic                    valid_q, valid_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [N_IN-1:0]         work_q, work_d;
  logic [N_IN-1:0]         pending_q, pending_d;
  logic [WEIGHT_WIDTH-1:0] w_rdata;

  synapse_weight_rf #(
    .N_IN (N_IN),
    .AW   (AW)
  ) u_weights (
    .clk     (clk),
    .rst_i   (rst_n),
    .we_i    (w_we),
    .waddr_i (w_addr),
    .wdata_i (w_data),
    .raddr_i (idx_q),
    .rdata_o (w_rdata)
  );

  // State and datapath registers; reset (active-high) aborts any update.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      isyn_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      work_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      isyn_q    <= isyn_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic: tick acceptance, decay, serial weight scan, publish.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    isyn_d    = isyn_q;
    valid_d   = 1'b0;
    idx_d     = idx_q;
    work_d    = work_q;
    pending_d = pending_q | spike_in;
    case (state_q)
      IDLE: begin
        if (tick) begin
          // Snapshot everything seen so far; this cycle's spikes are both
          // in the snapshot and kept for the next update, so none are lost.
          work_d    = pending_q | spike_in;
          pending_d = spike_in;
          idx_d     = '0;
          state_d   = DECAY;
        end
      end
      DECAY: begin
        acc_d   = acc_q - (acc_q >> TAU);
        state_d = SCAN;
      end
      SCAN: begin
        if (work_q[idx_q]) begin
          acc_d = sat_add(acc_q, w_rdata, ISYN_MAX_C);
        end
        if (idx_q == LAST_IDX) begin
          state_d = OUTPUT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      OUTPUT: begin
        isyn_d  = acc_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign isyn       = isyn_q;
  assign isyn_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_synapse_current_gen.sv
// Bench for synapse_current_gen: expected isyn values are pushed when a tick
// is issued and popped by a monitor whenever isyn_valid pulses.
module tb_synapse_current_gen;

  localparam int N_IN = 4;
  localparam int AW   = 2;

  logic            clk;
  logic            rst_n;
  logic [N_IN-1:0] spike_in;
  logic            tick;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_data;
  logic [7:0]      isyn;
  logic            isyn_valid;
  logic            busy;
  logic [1:0]      state_dbg;

  int checks   = 0;
  int failures = 0;
  int valid_seen = 0;
  logic [7:0] exp_q[$];

  synapse_current_gen #(.N_IN(N_IN), .TAU(2), .ISYN_MAX(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .tick       (tick),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .isyn       (isyn),
    .isyn_valid (isyn_valid),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every isyn_valid pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst_n && isyn_valid) begin
      valid_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid isyn=%0d with no expected value", isyn);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (isyn !== e) begin
          failures++;
          $display("FAIL sb_isyn got=%0d exp=%0d", isyn, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_w(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Drive a tick for one cycle; returns at the negedge after the accept edge.
  task automatic send_tick(input logic [N_IN-1:0] s, input logic [7:0] exp_val);
    @(negedge clk);
    spike_in = s; tick = 1'b1;
    exp_q.push_back(exp_val);
    @(negedge clk);
    spike_in = '0; tick = 1'b0;
  endtask

  // Wait (bounded) for isyn_valid; lat is the edge count after acceptance.
  task automatic wait_valid(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (isyn_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL valid_timeout no isyn_valid within 20 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat, bc;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spike_in = 4'($urandom_range(0, 15));
      tick = 1'($urandom_range(0, 1));
      w_we = 1'($urandom_range(0, 1));
      w_addr = 2'($urandom_range(0, 3));
      w_data = 8'($urandom_range(0, 255));
      checks++;
      if (isyn !== 8'd0 || isyn_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs isyn=%0d valid=%b busy=%b exp 0/0/0", isyn, isyn_valid, busy);
      end
    end
    @(negedge clk);
    spike_in = '0; tick = 1'b0; w_we = 1'b0;
    rst_n = 1'b0;
    send_tick('0, 8'd0);
    wait_valid(lat, bc);
    checks++;
    if (lat != 6) begin
      failures++;
      $display("FAIL reset_latency got=%0d exp=6", lat);
    end
  endtask

  task automatic test_weighted_sum();
    int lat, bc, v0;
    write_w(0, 8'd10); write_w(1, 8'd20); write_w(2, 8'd30); write_w(3, 8'd40);
    @(negedge clk);
    spike_in = 4'b0101;
    @(negedge clk);
    spike_in = '0;
    repeat (2) @(negedge clk);
    v0 = valid_seen;
    send_tick('0, 8'd40);
    wait_valid(lat, bc);
    checks++;
    if (bc != 6) begin
      failures++;
      $display("FAIL busy_cycles got=%0d exp=6", bc);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_valid got=%b exp=0", busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (valid_seen - v0 != 1) begin
      failures++;
      $display("FAIL single_pulse got=%0d exp=1", valid_seen - v0);
    end
    checks++;
    if (isyn !== 8'd40) begin
      failures++;
      $display("FAIL isyn_hold got=%0d exp=40", isyn);
    end
  endtask

  task automatic test_decay();
    int lat, bc;
    logic [7:0] seq [3];
    seq[0] = 8'd30; seq[1] = 8'd23; seq[2] = 8'd18;
    for (int i = 0; i < 3; i++) begin
      send_tick('0, seq[i]);
      wait_valid(lat, bc);
    end
  endtask

  task automatic test_saturation();
    int lat, bc;
    for (int i = 0; i < N_IN; i++) write_w(AW'(i), 8'd200);
    send_tick(4'b1111, 8'd255);
    wait_valid(lat, bc);
    // Spikes of the accepted tick cycle remain pending; clear them via a
    // reset-free path is impossible, so this no-spike tick still sees them.
    // 255 - 63 = 192, plus the re-captured 4'b1111 saturates again.
    send_tick('0, 8'd255);
    wait_valid(lat, bc);
    // Now pending is empty: pure decay 255 -> 192.
    send_tick('0, 8'd192);
    wait_valid(lat, bc);
  endtask

  task automatic test_back_to_back();
    int lat, bc, v0;
    write_w(0, 8'd10); write_w(1, 8'd20); write_w(2, 8'd30); write_w(3, 8'd40);
    v0 = valid_seen;
    send_tick('0, 8'd144);          // 192 - 48
    repeat (2) @(negedge clk);      // now mid-SCAN
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid_scan got=%b exp=1", busy);
    end
    spike_in = 4'b0010; tick = 1'b1;
    @(negedge clk);
    spike_in = '0; tick = 1'b0;
    wait_valid(lat, bc);
    repeat (8) @(negedge clk);
    checks++;
    if (valid_seen - v0 != 1) begin
      failures++;
      $display("FAIL ignored_tick pulses got=%0d exp=1", valid_seen - v0);
    end
    send_tick('0, 8'd128);          // 144 - 36 + 20
    wait_valid(lat, bc);
  endtask

  task automatic test_write_during_scan();
    int lat, bc;
    send_tick(4'b0001, 8'd106);     // 128 - 32 + old weight 10
    @(negedge clk);                 // after decay edge; idx 0 scanned next edge
    w_we = 1'b1; w_addr = 2'd0; w_data = 8'd100;
    @(negedge clk);
    w_we = 1'b0;
    wait_valid(lat, bc);
    // 0001 from the previous tick cycle is still pending: 106 - 26 + 100.
    send_tick('0, 8'd180);
    wait_valid(lat, bc);
  endtask

  task automatic test_reset_mid_scan();
    int lat, bc, v0;
    send_tick(4'b1111, 8'd0);
    void'(exp_q.pop_back());        // this update is aborted
    repeat (3) @(negedge clk);
    v0 = valid_seen;
    rst_n = 1'b1;
    #1;
    checks++;
    if (isyn !== 8'd0 || isyn_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_scan isyn=%0d valid=%b busy=%b state=%0d exp 0/0/0/0",
               isyn, isyn_valid, busy, state_dbg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (valid_seen != v0) begin
      failures++;
      $display("FAIL reset_no_valid pulses got=%0d exp=0", valid_seen - v0);
    end
    send_tick(4'b1111, 8'd0);       // weights cleared by reset
    wait_valid(lat, bc);
  endtask

  initial begin
    rst_n = 1'b1; spike_in = '0; tick = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    test_reset();
    test_weighted_sum();
    test_decay();
    test_saturation();
    test_back_to_back();
    test_write_during_scan();
    test_reset_mid_scan();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover entries=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
